// File: rtl/hpi_pkg.sv
// hpi_pkg: shared constants, strobe-state encoding and STATUS packing for the
// HPI responder. Optional feature macro used elsewhere: HPI_RESP_INT_EN.
package hpi_pkg;

  // Register select values on hpi_addr
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // STATUS register bit positions
  localparam int ST_RX_FULL = 0;
  localparam int ST_TX_FULL = 8;
  localparam int ST_PERR    = 15;

  // Where the responder is within a host access
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERROR = 2'd3
  } strobe_state_e;

  // Assemble the STATUS word; every bit not listed reads as zero
  function automatic logic [15:0] status_word(input logic rx_full,
                                              input logic tx_full,
                                              input logic perr);
    logic [15:0] w;
    w             = 16'h0000;
    w[ST_RX_FULL] = rx_full;
    w[ST_TX_FULL] = tx_full;
    w[ST_PERR]    = perr;
    return w;
  endfunction

endpackage

// File: rtl/hpi_resp_ram.sv
// hpi_resp_ram: single-port synchronous word RAM backing the HPI DATA register.
// Read data appears one cycle after the address is presented; contents are
// deliberately not reset.
module hpi_resp_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];
  logic [15:0] rdata_q;

  // Write port and registered read of the same address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hpi_responder.sv
// hpi_responder: target end of the 4-register host-port interface (DATA,
// MAILBOX, ADDRESS, STATUS) backed by an internal word RAM.
// Optional feature: define HPI_RESP_INT_EN to add the hpi_int output
// (registered OR of the tx-mailbox-full and protocol-error STATUS bits).
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_AW   = 10,
  parameter int ADDR_INC = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ack,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_wr
`ifdef HPI_RESP_INT_EN
  ,output logic       hpi_int
`endif
);

  localparam logic [15:0] ADDR_STEP = 16'(ADDR_INC);

  // Registered strobe levels and their one-cycle history
  logic rd_act_q,  rd_act_d;
  logic wr_act_q,  wr_act_d;
  logic err_act_q, err_act_d;
  logic rd_prev_q, rd_prev_d;
  logic wr_prev_q, wr_prev_d;

  // Sampled host address/data
  logic [1:0]  addr_q,  addr_d;
  logic [1:0]  rsel_q,  rsel_d;
  logic [1:0]  wsel_q,  wsel_d;
  logic [15:0] wdata_q, wdata_d;

  // Access state and host-visible registers
  strobe_state_e state_q, state_d;
  logic [15:0] data_out_q, data_out_d;
  logic        oe_q,       oe_d;
  logic [15:0] address_q,  address_d;
  logic [15:0] rx_data_q,  rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] tx_data_q,  tx_data_d;
  logic        tx_full_q,  tx_full_d;
  logic        perr_q,     perr_d;
`ifdef HPI_RESP_INT_EN
  logic        int_q,      int_d;
`endif

  // Combinational helpers
  logic              rd_s, wr_s, err_s;
  logic              rd_fall_s, wr_fall_s;
  logic              mbx_commit_s;
  logic              tx_rd_end_s;
  logic [15:0]       status_s;
  logic              ram_we_s;
  logic [MEM_AW-1:0] ram_addr_s;
  logic [15:0]       ram_rdata_s;

  // Decode the raw strobes into read, write and illegal (both low) activity
  always_comb begin
    rd_s  = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
    wr_s  = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;
    err_s = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
  end

  assign rd_fall_s  = rd_prev_q && !rd_act_q;
  assign wr_fall_s  = wr_prev_q && !wr_act_q;
  assign status_s   = status_word(rx_valid_q, tx_full_q, perr_q);
  // RAM always addresses the current ADDRESS; upper bits are ignored (aliasing)
  assign ram_addr_s = address_q[MEM_AW:1];

  hpi_resp_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata_q),
    .rdata (ram_rdata_s)
  );

  // Next-state logic for the access FSM, registers and mailboxes
  always_comb begin
    // Sampling of the bus; write data/select keep their last wr_act-high value
    rd_act_d  = rd_s;
    wr_act_d  = wr_s;
    err_act_d = err_s;
    rd_prev_d = rd_act_q;
    wr_prev_d = wr_act_q;
    addr_d    = hpi_addr;
    if (wr_s) begin
      wdata_d = hpi_data_in;
      wsel_d  = hpi_addr;
    end else begin
      wdata_d = wdata_q;
      wsel_d  = wsel_q;
    end

    state_d      = state_q;
    rsel_d       = rsel_q;
    data_out_d   = data_out_q;
    oe_d         = oe_q;
    address_d    = address_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    tx_data_d    = tx_data_q;
    tx_full_d    = tx_full_q;
    perr_d       = perr_q;
    ram_we_s     = 1'b0;
    mbx_commit_s = 1'b0;
    tx_rd_end_s  = 1'b0;

    if (err_act_q) begin
      // Illegal strobe combination: abort whatever was in flight, no commit
      state_d = ERROR;
      oe_d    = 1'b0;
      perr_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_act_q) begin
            // RAM is being read at ADDRESS this cycle; output loads next cycle
            state_d = READ;
            rsel_d  = addr_q;
          end else if (wr_act_q) begin
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          if (rd_fall_s) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            case (rsel_q)
              HPI_DATA:    address_d   = address_q + ADDR_STEP;
              HPI_MAILBOX: tx_rd_end_s = 1'b1;
              HPI_ADDRESS: address_d   = address_q;
              HPI_STATUS:  address_d   = address_q;
              default:     address_d   = address_q;
            endcase
          end else if (!oe_q) begin
            // First cycle of the read: latch the selected register and drive
            oe_d = 1'b1;
            case (rsel_q)
              HPI_DATA:    data_out_d = ram_rdata_s;
              HPI_MAILBOX: data_out_d = tx_data_q;
              HPI_ADDRESS: data_out_d = address_q;
              HPI_STATUS:  data_out_d = status_s;
              default:     data_out_d = 16'h0000;
            endcase
          end else begin
            data_out_d = data_out_q;
          end
        end
        WRITE: begin
          if (wr_fall_s) begin
            state_d = IDLE;
            case (wsel_q)
              HPI_DATA: begin
                ram_we_s  = 1'b1;
                address_d = address_q + ADDR_STEP;
              end
              HPI_MAILBOX: mbx_commit_s = 1'b1;
              HPI_ADDRESS: address_d    = wdata_q;
              HPI_STATUS: begin
                if (wdata_q[ST_PERR]) begin
                  perr_d = 1'b0;
                end else begin
                  perr_d = perr_q;
                end
              end
              default: address_d = address_q;
            endcase
          end else begin
            state_d = WRITE;
          end
        end
        ERROR: begin
          // Stay parked until the bus is completely quiet again
          if (!rd_act_q && !wr_act_q) begin
            state_d = IDLE;
          end else begin
            state_d = ERROR;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end

    // Host-to-device mailbox: a host commit beats a simultaneous local ack
    if (mbx_commit_s) begin
      rx_data_d  = wdata_q;
      rx_valid_d = 1'b1;
    end else if (mbx_rx_ack) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    // Device-to-host mailbox: a local post beats a simultaneous host read end
    if (mbx_tx_wr) begin
      tx_data_d = mbx_tx_data;
      tx_full_d = 1'b1;
    end else if (tx_rd_end_s) begin
      tx_full_d = 1'b0;
    end else begin
      tx_full_d = tx_full_q;
    end

`ifdef HPI_RESP_INT_EN
    int_d = tx_full_q || perr_q;
`endif
  end

  // State and register update; reset aborts any access without committing
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_act_q   <= 1'b0;
      wr_act_q   <= 1'b0;
      err_act_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      addr_q     <= 2'd0;
      rsel_q     <= 2'd0;
      wsel_q     <= 2'd0;
      wdata_q    <= 16'h0000;
      state_q    <= IDLE;
      data_out_q <= 16'h0000;
      oe_q       <= 1'b0;
      address_q  <= 16'h0000;
      rx_data_q  <= 16'h0000;
      rx_valid_q <= 1'b0;
      tx_data_q  <= 16'h0000;
      tx_full_q  <= 1'b0;
      perr_q     <= 1'b0;
`ifdef HPI_RESP_INT_EN
      int_q      <= 1'b0;
`endif
    end else begin
      rd_act_q   <= rd_act_d;
      wr_act_q   <= wr_act_d;
      err_act_q  <= err_act_d;
      rd_prev_q  <= rd_prev_d;
      wr_prev_q  <= wr_prev_d;
      addr_q     <= addr_d;
      rsel_q     <= rsel_d;
      wsel_q     <= wsel_d;
      wdata_q    <= wdata_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      address_q  <= address_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_full_q  <= tx_full_d;
      perr_q     <= perr_d;
`ifdef HPI_RESP_INT_EN
      int_q      <= int_d;
`endif
    end
  end

  assign hpi_data_out = data_out_q;
  assign hpi_data_oe  = oe_q;
  assign mbx_rx_data  = rx_data_q;
  assign mbx_rx_valid = rx_valid_q;
`ifdef HPI_RESP_INT_EN
  assign hpi_int      = int_q;
`endif

endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: directed self-checking bench for hpi_responder.
module tb_hpi_responder;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        Clk, Reset;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n;
  logic [15:0] hpi_data_in, hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] mbx_rx_data;
  logic        mbx_rx_valid, mbx_rx_ack;
  logic [15:0] mbx_tx_data;
  logic        mbx_tx_wr;
`ifdef HPI_RESP_INT_EN
  logic        hpi_int;
`endif

  int total = 0;
  int bad   = 0;

  hpi_responder #(.MEM_AW(10), .ADDR_INC(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hpi_addr     (hpi_addr),
    .hpi_cs_n     (hpi_cs_n),
    .hpi_r_n      (hpi_r_n),
    .hpi_w_n      (hpi_w_n),
    .hpi_data_in  (hpi_data_in),
    .hpi_data_out (hpi_data_out),
    .hpi_data_oe  (hpi_data_oe),
    .mbx_rx_data  (mbx_rx_data),
    .mbx_rx_valid (mbx_rx_valid),
    .mbx_rx_ack   (mbx_rx_ack),
    .mbx_tx_data  (mbx_tx_data),
    .mbx_tx_wr    (mbx_tx_wr)
`ifdef HPI_RESP_INT_EN
    ,.hpi_int     (hpi_int)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic bus_idle();
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clk);
    hpi_cs_n = 1'b0; hpi_addr = a; hpi_data_in = d; hpi_w_n = 1'b0;
    repeat (3) @(negedge Clk);
    bus_idle();
    repeat (4) @(negedge Clk);
  endtask

  // Starts a read and waits (bounded) for hpi_data_oe; leaves strobe asserted
  task automatic read_begin(input logic [1:0] a, output logic seen);
    seen = 1'b0;
    @(negedge Clk);
    hpi_cs_n = 1'b0; hpi_addr = a; hpi_r_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (hpi_data_oe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL read_oe_timeout: got oe=0 required oe=1 (addr=%0d)", a);
    end
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    logic seen;
    read_begin(a, seen);
    d = hpi_data_out;
    bus_idle();
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    total++; if (hpi_data_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b required 0", hpi_data_oe); end
    total++; if (hpi_data_out !== 16'h0000) begin bad++; $display("FAIL rst_dout: got %h required 0000", hpi_data_out); end
    total++; if (mbx_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b required 0", mbx_rx_valid); end
    total++; if (mbx_rx_data !== 16'h0000) begin bad++; $display("FAIL rst_rx_data: got %h required 0000", mbx_rx_data); end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    host_read(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_status: got %h required 0000", d); end
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_address: got %h required 0000", d); end
  endtask

  task automatic test_data();
    logic [15:0] d;
    host_write(A_ADDR, 16'h0040);
    host_write(A_DATA, 16'h1234);
    host_write(A_DATA, 16'h5678);
    host_write(A_ADDR, 16'h0040);
    host_read(A_DATA, d);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL data_rd0: got %h required 1234", d); end
    host_read(A_DATA, d);
    total++; if (d !== 16'h5678) begin bad++; $display("FAIL data_rd1: got %h required 5678", d); end
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0044) begin bad++; $display("FAIL data_addr: got %h required 0044", d); end
  endtask

  task automatic test_rx_mailbox();
    logic [15:0] d;
    host_write(A_MBX, 16'hBEEF);
    total++; if (mbx_rx_valid !== 1'b1) begin bad++; $display("FAIL rx_valid: got %b required 1", mbx_rx_valid); end
    total++; if (mbx_rx_data !== 16'hBEEF) begin bad++; $display("FAIL rx_data: got %h required beef", mbx_rx_data); end
    host_read(A_STAT, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL rx_status: got %h required 0001", d); end
    @(negedge Clk); mbx_rx_ack = 1'b1;
    @(negedge Clk); mbx_rx_ack = 1'b0;
    @(negedge Clk);
    total++; if (mbx_rx_valid !== 1'b0) begin bad++; $display("FAIL rx_ack_valid: got %b required 0", mbx_rx_valid); end
    host_read(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rx_ack_status: got %h required 0000", d); end
  endtask

  task automatic test_tx_mailbox();
    logic [15:0] d;
    @(negedge Clk); mbx_tx_data = 16'hCAFE; mbx_tx_wr = 1'b1;
    @(negedge Clk); mbx_tx_wr = 1'b0;
    host_read(A_STAT, d);
    total++; if (d !== 16'h0100) begin bad++; $display("FAIL tx_status: got %h required 0100", d); end
`ifdef HPI_RESP_INT_EN
    total++; if (hpi_int !== 1'b1) begin bad++; $display("FAIL tx_int: got %b required 1", hpi_int); end
`endif
    host_read(A_MBX, d);
    total++; if (d !== 16'hCAFE) begin bad++; $display("FAIL tx_data: got %h required cafe", d); end
    host_read(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL tx_cleared: got %h required 0000", d); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    host_write(A_ADDR, 16'hFFFE);
    host_write(A_DATA, 16'hAAAA);
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL wrap_addr: got %h required 0000", d); end
    host_write(A_ADDR, 16'h07FE);
    host_read(A_DATA, d);
    total++; if (d !== 16'hAAAA) begin bad++; $display("FAIL wrap_alias: got %h required aaaa", d); end
  endtask

  task automatic test_protocol_error();
    logic [15:0] d;
    logic        seen;
    host_write(A_ADDR, 16'h0040);
    // Write in progress, then read strobe joins it
    @(negedge Clk);
    hpi_cs_n = 1'b0; hpi_addr = A_DATA; hpi_data_in = 16'hDEAD; hpi_w_n = 1'b0;
    repeat (2) @(negedge Clk);
    hpi_r_n = 1'b0;
    repeat (2) @(negedge Clk);
    bus_idle();
    repeat (4) @(negedge Clk);
    host_read(A_STAT, d);
    total++; if (d !== 16'h8000) begin bad++; $display("FAIL perr_status: got %h required 8000", d); end
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0040) begin bad++; $display("FAIL perr_addr: got %h required 0040", d); end
    host_read(A_DATA, d);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL perr_ram: got %h required 1234", d); end
    // Error during an active read: oe drops, no increment
    read_begin(A_DATA, seen);
    hpi_w_n = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (hpi_data_oe !== 1'b0) begin bad++; $display("FAIL perr_oe_drop: got %b required 0", hpi_data_oe); end
    bus_idle();
    repeat (4) @(negedge Clk);
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0042) begin bad++; $display("FAIL perr_no_inc: got %h required 0042", d); end
    host_write(A_STAT, 16'h8000);
    host_read(A_STAT, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL perr_clear: got %h required 0000", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        seen;
    host_write(A_MBX, 16'h1111);
    // Host commit of 0x2222 lands in the same cycle as a local ack
    @(negedge Clk);
    hpi_cs_n = 1'b0; hpi_addr = A_MBX; hpi_data_in = 16'h2222; hpi_w_n = 1'b0;
    repeat (3) @(negedge Clk);
    bus_idle();
    @(negedge Clk); mbx_rx_ack = 1'b1;
    @(negedge Clk); mbx_rx_ack = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (mbx_rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid: got %b required 1", mbx_rx_valid); end
    total++; if (mbx_rx_data !== 16'h2222) begin bad++; $display("FAIL b2b_rx_data: got %h required 2222", mbx_rx_data); end
    @(negedge Clk); mbx_rx_ack = 1'b1;
    @(negedge Clk); mbx_rx_ack = 1'b0;
    // Local post coincides with the end of a host MAILBOX read
    @(negedge Clk); mbx_tx_data = 16'h1357; mbx_tx_wr = 1'b1;
    @(negedge Clk); mbx_tx_wr = 1'b0;
    read_begin(A_MBX, seen);
    d = hpi_data_out;
    total++; if (d !== 16'h1357) begin bad++; $display("FAIL b2b_tx_rd: got %h required 1357", d); end
    bus_idle();
    @(negedge Clk); mbx_tx_data = 16'h2468; mbx_tx_wr = 1'b1;
    @(negedge Clk); mbx_tx_wr = 1'b0;
    repeat (3) @(negedge Clk);
    host_read(A_STAT, d);
    total++; if (d !== 16'h0100) begin bad++; $display("FAIL b2b_tx_status: got %h required 0100", d); end
    host_read(A_MBX, d);
    total++; if (d !== 16'h2468) begin bad++; $display("FAIL b2b_tx_data: got %h required 2468", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] d;
    logic        seen;
    host_write(A_ADDR, 16'h0010);
    read_begin(A_DATA, seen);
    Reset = 1'b1;
    #1;
    total++; if (hpi_data_oe !== 1'b0) begin bad++; $display("FAIL rstmid_oe: got %b required 0", hpi_data_oe); end
    total++; if (hpi_data_out !== 16'h0000) begin bad++; $display("FAIL rstmid_dout: got %h required 0000", hpi_data_out); end
    @(negedge Clk);
    bus_idle();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    host_read(A_ADDR, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rstmid_addr: got %h required 0000", d); end
  endtask

  initial begin
    Reset       = 1'b1;
    hpi_addr    = 2'd0;
    hpi_data_in = 16'h0000;
    mbx_rx_ack  = 1'b0;
    mbx_tx_data = 16'h0000;
    mbx_tx_wr   = 1'b0;
    bus_idle();
    test_reset();
    test_data();
    test_rx_mailbox();
    test_tx_mailbox();
    test_wrap();
    test_protocol_error();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- Synthesizable HPI target: the responder end of the 4-register host-port interface that the Nios software drives through the otg_hpi address/cs/r/w/data PIOs.
- Implements the DATA, MAILBOX, ADDRESS and STATUS registers, backed by an internal word RAM.
- Uses: loopback and bring-up target when the USB controller is absent, and the bus-functional responder for the SoC simulation bench.

Parameters:
- MEM_AW, 10, word-address width of the internal RAM (2^MEM_AW x 16 bits).
- ADDR_INC, 2, byte increment applied to the ADDRESS register after each DATA access.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  reset, asynchronous, active-high.
- hpi_addr  input  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- hpi_cs_n  input  1  chip select, active-low.
- hpi_r_n  input  1  read strobe, active-low.
- hpi_w_n  input  1  write strobe, active-low.
- hpi_data_in  input  16  write data from the initiator.
- hpi_data_out  output  16  read data to the initiator.
- hpi_data_oe  output  1  high while the responder drives hpi_data_out.
- mbx_rx_data  output  16  last host-to-device mailbox word.
- mbx_rx_valid  output  1  host-to-device mailbox full.
- mbx_rx_ack  input  1  local side consumes the mailbox (single-cycle pulse).
- mbx_tx_data  input  16  device-to-host mailbox word.
- mbx_tx_wr  input  1  local side posts mbx_tx_data (single-cycle pulse).

Behaviour:
- All inputs are sampled on Clk rising edges; the initiator is slow (software PIO).
- Strobes: rd_act = !cs_n & !r_n & w_n; wr_act = !cs_n & !w_n & r_n. Each is registered once; the previous value is kept for edge detection.
- Read start (rd_act rising):
  - the selected register, or RAM[ADDRESS[MEM_AW:1]] for DATA, is latched into hpi_data_out one cycle later;
  - hpi_data_oe asserts on that same cycle;
  - both hold until rd_act falls; hpi_data_oe then deasserts on the next cycle.
- Read end (rd_act falling):
  - DATA: ADDRESS += ADDR_INC, 16-bit wrap.
  - MAILBOX: the device-to-host mailbox is consumed and STATUS[8] clears.
- Write commit (wr_act falling): uses hpi_data_in sampled on the last cycle wr_act was high.
  - DATA: RAM[ADDRESS[MEM_AW:1]] <= data, then ADDRESS += ADDR_INC.
  - MAILBOX: mbx_rx_data <= data; mbx_rx_valid and STATUS[0] set.
  - ADDRESS: ADDRESS <= data.
  - STATUS: writing 1 to bit15 clears it; other bits are read-only.
- RAM indexing uses ADDRESS[MEM_AW:1]; upper bits are ignored, so the RAM aliases. ADDRESS 0xFFFE + 2 wraps to 0x0000.
- STATUS layout:
  - bit0: rx mailbox full.
  - bit8: tx mailbox full.
  - bit15: sticky protocol error.
  - all other bits read 0.
- Protocol error: cs_n low with r_n and w_n both low for any cycle.
  - bit15 sets.
  - Any in-progress access is aborted with no commit and no increment.
  - hpi_data_oe drops on the next cycle.
- mbx_rx_ack clears mbx_rx_valid and STATUS[0]. If a host MAILBOX commit lands in the same cycle, the commit wins: valid stays 1 with the new data.
- mbx_tx_wr loads the tx mailbox and sets STATUS[8]. If it coincides with a host MAILBOX read end, set wins.
- cs_n rising mid-strobe counts as the strobe end: commit or increment as above.
- Reset values: hpi_data_out=0, hpi_data_oe=0, ADDRESS=0, STATUS=0, mbx_rx_data=0, mbx_rx_valid=0, tx mailbox=0, strobe history=inactive. RAM contents are not reset.
- Asserting Reset mid-access aborts it with no commit and no increment.

Optional Feature:
- Macro: HPI_RESP_INT_EN.
- Defined: adds output hpi_int (1 bit), registered = STATUS[8] | STATUS[15]; reset value 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package hpi_pkg holds:
  - register-select constants HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3;
  - STATUS bit indices (0, 8, 15);
  - a strobe-state enum IDLE/READ/WRITE/ERROR.
- Sub-module hpi_resp_ram: single-port synchronous word RAM (MEM_AW x 16), one-cycle read latency, aligned with the output latch.

Test Plan:
- Write ADDRESS=0x0040; write DATA 0x1234 then 0x5678; write ADDRESS=0x0040; read DATA twice -> 0x1234 then 0x5678; final ADDRESS reads 0x0044.
- Host writes MAILBOX 0xBEEF -> mbx_rx_valid=1, mbx_rx_data=0xBEEF, STATUS reads 0x0001. Pulse mbx_rx_ack -> STATUS reads 0x0000.
- mbx_tx_wr with 0xCAFE -> STATUS=0x0100 (hpi_int=1 when HPI_RESP_INT_EN). Host reads MAILBOX -> 0xCAFE; after the read STATUS=0x0000.
- ADDRESS=0xFFFE, write DATA 0xAAAA -> ADDRESS reads 0x0000. With MEM_AW=10, reading address 0x07FE returns 0xAAAA (alias).
- Drive r_n=w_n=0 with cs_n=0 -> STATUS bit15=1, RAM and ADDRESS unchanged. Write STATUS 0x8000 -> bit15 clears.
- Assert Reset mid-read with hpi_data_oe=1 -> hpi_data_oe=0 and ADDRESS=0 immediately, with no increment.
